// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: funct3 codes, FSM states,
// access-size and byte-lane decoding.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMrgRd,
    StWrite,
    StResp
  } state_t;

  // Access size in bytes (1/2/4/8) from funct3[1:0].
  function automatic logic [3:0] size_from_funct3(input logic [2:0] funct3);
    logic [3:0] size;
    case (funct3[1:0])
      2'b00:   size = 4'd1;
      2'b01:   size = 4'd2;
      2'b10:   size = 4'd4;
      default: size = 4'd8;
    endcase
    return size;
  endfunction

  function automatic logic [7:0] bytemask_from(input logic [3:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      4'd1:    base = 8'h01;
      4'd2:    base = 8'h03;
      4'd4:    base = 8'h0f;
      default: base = 8'hff;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response bus between the execute stage (master) and the load/store sequencer (slave).
interface lsu_mem_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;

  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_fault;

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault
  );

endinterface

// File: rtl/lsu_load_extend.sv
// Selects the addressed bytes from a memory doubleword and sign- or zero-extends them
// according to the load funct3.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] ext
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    // funct3[2] set selects the unsigned variants (LBU/LHU/LWU).
    unique case (funct3[1:0])
      2'b00:   ext = funct3[2] ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
      2'b01:   ext = funct3[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'b10:   ext = funct3[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: turns RV64 byte/half/word/double loads and stores into doubleword
// accesses on a single-port-read/single-port-write data memory, using read-modify-write.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  lsu_mem_ctrl_if.slave   lsu,
  output logic            mem_read,
  output logic            mem_write,
  output logic [63:0]     mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  state_t      state_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] merged_q;

  logic        resp_valid_q;
  logic [63:0] resp_rdata_q;
  logic        resp_mis_q;
  logic        resp_fault_q;

  // Request checks, evaluated on the live inputs in the accept cycle.
  logic [3:0]  req_size;
  logic [2:0]  align_mask;
  logic        req_illegal;
  logic        req_out_of_range;
  logic        req_misaligned;

  always_comb begin
    req_size         = size_from_funct3(lsu.req_funct3);
    align_mask       = 3'(req_size - 4'd1);
    req_illegal      = lsu.req_is_store ? lsu.req_funct3[2] : (lsu.req_funct3 == 3'b111);
    req_out_of_range = {3'b000, lsu.req_addr[63:3]} >= 64'(MEM_WORDS);
    req_misaligned   = |(lsu.req_addr[2:0] & align_mask);
  end

  // Read-modify-write merge of the latched store data into the fetched doubleword.
  logic [7:0]  byte_mask;
  logic [63:0] bit_mask;
  logic [63:0] shifted_wdata;
  logic [63:0] merge_val;

  always_comb begin
    byte_mask = bytemask_from(size_from_funct3(funct3_q), addr_q[2:0]);
    bit_mask  = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    end
    shifted_wdata = wdata_q << {addr_q[2:0], 3'b000};
    merge_val     = (mem_rdata & ~bit_mask) | (shifted_wdata & bit_mask);
  end

  logic [63:0] load_val;

  lsu_load_extend u_load_extend (
    .rdata  (mem_rdata),
    .off    (addr_q[2:0]),
    .funct3 (funct3_q),
    .ext    (load_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      merged_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_mis_q   <= 1'b0;
      resp_fault_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (lsu.req_valid) begin
            is_store_q <= lsu.req_is_store;
            funct3_q   <= lsu.req_funct3;
            addr_q     <= lsu.req_addr;
            wdata_q    <= lsu.req_wdata;
            if (req_illegal || req_out_of_range) begin
              resp_fault_q <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
            end else if (req_misaligned) begin
              resp_mis_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
            end else if (!lsu.req_is_store) begin
              state_q <= StLoad;
            end else if (lsu.req_funct3[1:0] == SD[1:0]) begin
              // Full doubleword store needs no read of the old contents.
              merged_q <= lsu.req_wdata;
              state_q  <= StWrite;
            end else begin
              state_q <= StMrgRd;
            end
          end
        end
        StLoad: begin
          resp_rdata_q <= load_val;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StMrgRd: begin
          merged_q <= merge_val;
          state_q  <= StWrite;
        end
        StWrite: begin
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          resp_rdata_q <= '0;
          resp_mis_q   <= 1'b0;
          resp_fault_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory strobes decode from state alone so an async reset drops them at once.
  always_comb begin
    mem_read  = (state_q == StLoad) || (state_q == StMrgRd);
    mem_write = (state_q == StWrite);
    mem_addr  = (mem_read || mem_write) ? {addr_q[63:3], 3'b000} : 64'd0;
    mem_wdata = mem_write ? merged_q : '0;
  end

  assign lsu.req_ready       = (state_q == StIdle);
  assign lsu.resp_valid      = resp_valid_q;
  assign lsu.resp_rdata      = resp_rdata_q;
  assign lsu.resp_misaligned = resp_mis_q;
  assign lsu.resp_fault      = resp_fault_q;

  logic unused_is_store;
  assign unused_is_store = is_store_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: table of single requests against a behavioural data
// memory, plus hand-written reset-abort and back-to-back sequences.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  localparam int unsigned MemWords = 1024;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic [63:0] mem [0:MemWords-1];
  logic [63:0] last_wdata;

  int tests = 0;
  int fails = 0;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(
    .XLEN      (64),
    .MEM_WORDS (MemWords)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lsu       (bus),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[12:3]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[12:3]] <= mem_wdata;
  end

  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        mis;
    logic        flt;
    int          lat;
    logic        rd;
    logic        wr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic st, logic [2:0] f3, logic [63:0] a,
                              logic [63:0] w, logic [63:0] r, logic mis, logic flt,
                              int lat, logic rd, logic wr);
    vec_t v;
    v.name = n; v.st = st; v.f3 = f3; v.addr = a; v.wdata = w; v.rdata = r;
    v.mis = mis; v.flt = flt; v.lat = lat; v.rd = rd; v.wr = wr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v);
    int   cyc;
    logic saw_rd;
    logic saw_wr;
    logic done;
    saw_rd = 1'b0;
    saw_wr = 1'b0;
    done   = 1'b0;
    @(negedge clk);
    cyc = 0;
    while (bus.req_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({v.name, " ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid    = 1'b1;
    bus.req_is_store = v.st;
    bus.req_funct3   = v.f3;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    @(posedge clk);
    #1;
    // Scramble the request after accept; the DUT must use its latched copy.
    bus.req_valid    = 1'b0;
    bus.req_is_store = ~v.st;
    bus.req_funct3   = 3'b111;
    bus.req_addr     = 64'hdead_beef_dead_bee8;
    bus.req_wdata    = '1;
    for (cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (mem_read) saw_rd = 1'b1;
      if (mem_write) begin
        saw_wr     = 1'b1;
        last_wdata = mem_wdata;
      end
      if (bus.resp_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk({v.name, " latency"}, 64'(cyc), 64'(v.lat));
    if (done) begin
      chk({v.name, " rdata"}, bus.resp_rdata, v.rdata);
      chk({v.name, " misaligned"}, 64'(bus.resp_misaligned), 64'(v.mis));
      chk({v.name, " fault"}, 64'(bus.resp_fault), 64'(v.flt));
      chk({v.name, " mem_read seen"}, 64'(saw_rd), 64'(v.rd));
      chk({v.name, " mem_write seen"}, 64'(saw_wr), 64'(v.wr));
      @(negedge clk);
      chk({v.name, " resp pulse"}, 64'(bus.resp_valid), 64'd0);
    end
  endtask

  initial begin
    logic [5:0] exp_ready;
    logic [5:0] exp_rv;

    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'b000;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    last_wdata       = '0;
    for (int i = 0; i < int'(MemWords); i++) mem[i] = 64'(i) * 64'h0101;
    mem[32'h100 >> 3] = 64'h8877_6655_4433_2211;

    vecs.push_back(mk("lb_107",  0, LB,  64'h107, 0, 64'hffff_ffff_ffff_ff88, 0, 0, 2, 1, 0));
    vecs.push_back(mk("lbu_107", 0, LBU, 64'h107, 0, 64'h0000_0000_0000_0088, 0, 0, 2, 1, 0));
    vecs.push_back(mk("lh_106",  0, LH,  64'h106, 0, 64'hffff_ffff_ffff_8877, 0, 0, 2, 1, 0));
    vecs.push_back(mk("lhu_106", 0, LHU, 64'h106, 0, 64'h0000_0000_0000_8877, 0, 0, 2, 1, 0));
    vecs.push_back(mk("lw_104",  0, LW,  64'h104, 0, 64'hffff_ffff_8877_6655, 0, 0, 2, 1, 0));
    vecs.push_back(mk("lwu_104", 0, LWU, 64'h104, 0, 64'h0000_0000_8877_6655, 0, 0, 2, 1, 0));
    vecs.push_back(mk("lw_100",  0, LW,  64'h100, 0, 64'h0000_0000_4433_2211, 0, 0, 2, 1, 0));
    vecs.push_back(mk("lb_101",  0, LB,  64'h101, 0, 64'h0000_0000_0000_0022, 0, 0, 2, 1, 0));
    vecs.push_back(mk("lw_102_mis", 0, LW, 64'h102, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk("sh_102",  1, SH,  64'h102, 64'habcd, 0, 0, 0, 3, 1, 1));
    vecs.push_back(mk("ld_100",  0, LD,  64'h100, 0, 64'h8877_6655_abcd_2211, 0, 0, 2, 1, 0));
    vecs.push_back(mk("sd_108",  1, SD,  64'h108, 64'h0123_4567_89ab_cdef, 0, 0, 0, 2, 0, 1));
    vecs.push_back(mk("ld_108",  0, LD,  64'h108, 0, 64'h0123_4567_89ab_cdef, 0, 0, 2, 1, 0));
    vecs.push_back(mk("ld_f3_111", 0, 3'b111, 64'h100, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("ld_oor",  0, LD,  64'(MemWords) * 8, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("sb_10f",  1, SB,  64'h10f, 64'hffff_ffff_ffff_ff5a, 0, 0, 0, 3, 1, 1));
    vecs.push_back(mk("ld_108b", 0, LD,  64'h108, 0, 64'h5a23_4567_89ab_cdef, 0, 0, 2, 1, 0));
    vecs.push_back(mk("st_f3_100", 1, 3'b100, 64'h100, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("sd_104_mis", 1, SD, 64'h104, 64'h1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk("sd_oor_mis", 1, SD, 64'(MemWords) * 8 + 4, 64'h1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("sw_10c",  1, SW,  64'h10c, 64'h1122_3344, 0, 0, 0, 3, 1, 1));
    vecs.push_back(mk("ld_108c", 0, LD,  64'h108, 0, 64'h1122_3344_89ab_cdef, 0, 0, 2, 1, 0));
    vecs.push_back(mk("lh_10e",  0, LH,  64'h10e, 0, 64'h0000_0000_0000_1122, 0, 0, 2, 1, 0));

    // Outputs while held in reset.
    @(negedge clk);
    @(negedge clk);
    chk("rst req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst mem_read", 64'(mem_read), 64'd0);
    chk("rst mem_write", 64'(mem_write), 64'd0);
    chk("rst mem_addr", mem_addr, 64'd0);
    chk("rst mem_wdata", mem_wdata, 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_req(vecs[i]);
      if (vecs[i].name == "sh_102") begin
        chk("sh_102 mem_wdata", last_wdata, 64'h8877_6655_abcd_2211);
      end
    end

    // Reset asserted during the WRITE cycle of an SB must abort the write.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b1;
    bus.req_funct3   = SB;
    bus.req_addr     = 64'h100;
    bus.req_wdata    = 64'h77;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort C1 mem_read", 64'(mem_read), 64'd1);
    @(negedge clk);
    chk("abort C2 mem_write", 64'(mem_write), 64'd1);
    chk("abort C2 mem_wdata", mem_wdata, 64'h8877_6655_abcd_2277);
    #1 rst_n = 1'b0;
    #1;
    chk("abort mem_write drop", 64'(mem_write), 64'd0);
    chk("abort mem_addr drop", mem_addr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort req_ready", 64'(bus.req_ready), 64'd1);
    chk("abort resp_valid", 64'(bus.resp_valid), 64'd0);
    run_req(mk("ld_after_abort", 0, LD, 64'h100, 0, 64'h8877_6655_abcd_2211, 0, 0, 2, 1, 0));

    // Held req_valid: each load accepted only after the previous RESP cycle.
    @(negedge clk);
    exp_ready        = 6'b100100;
    exp_rv           = 6'b001001;
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = LD;
    bus.req_addr     = 64'h100;
    bus.req_wdata    = '0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("b2b c%0d req_ready", i), 64'(bus.req_ready), 64'(exp_ready[5-i]));
      chk($sformatf("b2b c%0d resp_valid", i), 64'(bus.resp_valid), 64'(exp_rv[5-i]));
      if (exp_rv[5-i]) begin
        chk($sformatf("b2b c%0d rdata", i), bus.resp_rdata, 64'h8877_6655_abcd_2211);
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
